muldiv_seq: RTL and testbench
=============================

# muldiv_seq

Iterative RV64M multiply/divide sequencer attached to the EXE stage. When an M-extension instruction reaches EXE, it takes ownership of the stage and stalls the front of the pipeline. It runs a 64-iteration shift-add (MUL*) or restoring-division (DIV*/REM*) sequence, then releases the stage with a one-cycle result strobe merged into the EXE→MEM result path. It is the only block that sequences multi-cycle EXE occupancy.

## Interface
- XLEN, 64, operand/result width; only 64 is supported.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low; sampled on rising clk.
- StartE  in  1  a valid M-op is in EXE this cycle.
- FunctE  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- SrcA_E  in  XLEN  rs1 operand (post-forwarding).
- SrcB_E  in  XLEN  rs2 operand (post-forwarding).
- RD_E  in  5  destination register of the op.
- FlushE  in  1  kill the instruction in EXE (branch/jump redirect).
- StallE  out  1  hold IF/ID/EXE pipeline registers; insert a bubble into MEM.
- DoneE  out  1  one-cycle strobe; ResultE/RdOut valid.
- ResultE  out  XLEN  final result.
- RdOut  out  5  destination register of the completed op.

## Operation
- FSM states: IDLE, RUN, FIX, DONE.
- IDLE:
  - StartE & !FlushE captures operands, FunctE, RD_E.
  - Records signs: signed for MULH/DIV/REM on both operands; rs1 only for MULHSU.
  - Loads magnitudes into work registers, clears the 7-bit iteration counter, goes to RUN.
- Fast path from IDLE straight to DONE:
  - Divide-by-zero: quotient = all ones, remainder = SrcA_E.
  - Signed overflow (DIV/REM with SrcA = 0x8000_0000_0000_0000, SrcB = all ones): quotient = SrcA, remainder = 0.
- RUN: one iteration per cycle, counter 0..63; after iteration 63 goes to FIX.
  - MUL: 128-bit product register; LSB-driven conditional add of the multiplicand into the upper half, then shift right 1.
  - DIV: 64-bit remainder and quotient shift left; trial-subtract the divisor; set the quotient bit if the result is non-negative.
- FIX:
  - Applies two's-complement negation where the result sign requires it. Product is negated if the signs differ. Quotient is negated if the signs differ. Remainder takes the sign of the dividend.
  - Selects the output: low 64 bits for MUL, high 64 bits for MULH*; quotient or remainder for division.
  - Registers ResultE and goes to DONE.
- DONE: DoneE = 1, StallE = 0 so the pipeline advances. Goes unconditionally to IDLE; StartE in DONE belongs to the finished instruction and is ignored.
- StallE = (IDLE & StartE & !FlushE & !fastpath) | RUN | FIX. It is combinational so the stall takes effect in the issuing cycle.
- FlushE in RUN, FIX or DONE: next state IDLE, DoneE never asserted for that op. StallE is still driven for the current cycle per state.
- FlushE & StartE in IDLE: not accepted; StallE = 0.
- reset low: next state IDLE, all registers cleared. StallE and DoneE are forced 0 combinationally while reset is low.
- Reset values: StallE 0, DoneE 0, ResultE 0, RdOut 0.
- ResultE and RdOut hold their last value outside DONE.

## Timing
- StartE accepted at edge E0. RUN occupies cycles 1..64, FIX cycle 65, DONE cycle 66 (DoneE high). Back in IDLE at cycle 67.
- Normal latency: 66 cycles from acceptance to DoneE; StallE high for 66 cycles (acceptance cycle + 64 RUN + FIX).
- Fast-path latency: DoneE in the cycle after acceptance; StallE stays low throughout.
- Back-to-back M-ops: the second op is accepted no earlier than the IDLE cycle following DONE.
- The iteration counter never wraps; a counter value of 63 in RUN forces the transition to FIX.

## Test plan
- MUL 7 × −3 (0xFFFF…FFFD), RD_E = 5 → DoneE at cycle 66, ResultE = 0xFFFF_FFFF_FFFF_FFEB, RdOut = 5; StallE high cycles 0–65.
- MULHU 0xFFFF…FFFF × 0xFFFF…FFFF → ResultE = 0xFFFF_FFFF_FFFF_FFFE. MULH with the same operands → 0.
- DIV −20 / 3 → 0xFFFF…FFFA (−6). REM −20 / 3 → 0xFFFF…FFFE (−2). DIVU 20 / 3 → 6.
- DIVU 5 / 0 → all ones, DoneE in the next cycle, StallE never high. DIV 0x8000…0 / −1 → 0x8000…0. REM of the same operands → 0.
- FlushE asserted in RUN cycle 10 → IDLE next cycle, StallE low afterward, no DoneE. A new MUL 2 × 3 is then accepted and returns 6.
- reset low in RUN cycle 30 → StallE and DoneE 0 immediately; ResultE and RdOut 0 after the edge. A subsequent op completes normally.

Source files
------------

// File: rtl/muldiv_seq_if.sv
// Handshake between the EXE stage and the iterative multiply/divide sequencer.
interface muldiv_seq_if #(
  parameter int XLEN = 64
);
  logic            StartE;
  logic [2:0]      FunctE;
  logic [XLEN-1:0] SrcA_E;
  logic [XLEN-1:0] SrcB_E;
  logic [4:0]      RD_E;
  logic            FlushE;
  logic            StallE;
  logic            DoneE;
  logic [XLEN-1:0] ResultE;
  logic [4:0]      RdOut;

  // Pipeline side: issues M-ops and consumes stall/result
  modport master (
    output StartE, FunctE, SrcA_E, SrcB_E, RD_E, FlushE,
    input  StallE, DoneE, ResultE, RdOut
  );

  // Sequencer side
  modport slave (
    input  StartE, FunctE, SrcA_E, SrcB_E, RD_E, FlushE,
    output StallE, DoneE, ResultE, RdOut
  );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative RV64M multiply/divide sequencer owning the EXE stage.
//
// state | meaning
// IDLE  | waiting for an M-op; fast-path divides go straight to DONE
// RUN   | 64 shift-add / restoring-divide iterations, one per cycle
// FIX   | sign correction and result selection, result registered
// DONE  | one-cycle result strobe, pipeline released
module muldiv_seq (
  input  logic         clk,
  input  logic         reset,
  muldiv_seq_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [6:0]     cnt_q;
  logic [2:0]     funct_q;
  logic [4:0]     rd_q;
  logic           neg_res_q;
  logic           neg_rem_q;
  logic [63:0]    mcand_q;
  logic [127:0]   prod_q;
  logic [63:0]    result_q;
  logic [4:0]     rdout_q;

  // Operand decode for the op currently presented in EXE
  logic           is_div_in, sgn_a_in, sgn_b_in, neg_a, neg_b;
  logic [63:0]    mag_a, mag_b;
  logic           div_zero, div_ovf, fast, accept;
  logic [63:0]    fast_res;

  assign is_div_in = bus.FunctE[2];
  assign sgn_a_in  = (bus.FunctE == 3'b001) || (bus.FunctE == 3'b010) ||
                     (bus.FunctE == 3'b100) || (bus.FunctE == 3'b110);
  assign sgn_b_in  = (bus.FunctE == 3'b001) || (bus.FunctE == 3'b100) ||
                     (bus.FunctE == 3'b110);
  assign neg_a     = sgn_a_in & bus.SrcA_E[63];
  assign neg_b     = sgn_b_in & bus.SrcB_E[63];
  assign mag_a     = neg_a ? (~bus.SrcA_E + 64'd1) : bus.SrcA_E;
  assign mag_b     = neg_b ? (~bus.SrcB_E + 64'd1) : bus.SrcB_E;

  assign div_zero  = is_div_in && (bus.SrcB_E == 64'd0);
  assign div_ovf   = is_div_in && !bus.FunctE[0] &&
                     (bus.SrcA_E == 64'h8000_0000_0000_0000) &&
                     (bus.SrcB_E == 64'hFFFF_FFFF_FFFF_FFFF);
  assign fast      = div_zero || div_ovf;
  // Divide-by-zero takes precedence; REM variants select the remainder
  assign fast_res  = div_zero ? (bus.FunctE[1] ? bus.SrcA_E : 64'hFFFF_FFFF_FFFF_FFFF)
                              : (bus.FunctE[1] ? 64'd0 : bus.SrcA_E);
  assign accept    = (state_q == S_IDLE) && bus.StartE && !bus.FlushE;

  // One multiply iteration: conditional add into upper half, then shift right
  logic [64:0]    mul_sum;
  logic [127:0]   mul_step;
  assign mul_sum  = {1'b0, prod_q[127:64]} + (prod_q[0] ? {1'b0, mcand_q} : 65'd0);
  assign mul_step = {mul_sum, prod_q[63:1]};

  // One restoring-divide iteration on {remainder, dividend/quotient}
  logic [64:0]    rem_sh, div_diff;
  logic [127:0]   div_step;
  assign rem_sh   = {prod_q[127:64], prod_q[63]};
  assign div_diff = rem_sh - {1'b0, mcand_q};
  assign div_step = div_diff[64] ? {rem_sh[63:0], prod_q[62:0], 1'b0}
                                 : {div_diff[63:0], prod_q[62:0], 1'b1};

  // Sign correction and output selection
  logic [127:0]   prod_fix;
  logic [63:0]    quo_fix, rem_fix, fix_res;
  assign prod_fix = neg_res_q ? (~prod_q + 128'd1) : prod_q;
  assign quo_fix  = neg_res_q ? (~prod_q[63:0] + 64'd1) : prod_q[63:0];
  assign rem_fix  = neg_rem_q ? (~prod_q[127:64] + 64'd1) : prod_q[127:64];

  // Pick product half, quotient or remainder by funct3
  always_comb begin
    fix_res = prod_fix[63:0];
    case (funct_q)
      3'b000:                 fix_res = prod_fix[63:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_fix[127:64];
      3'b100, 3'b101:         fix_res = quo_fix;
      default:                fix_res = rem_fix;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = fast ? S_DONE : S_RUN;
      S_RUN: begin
        if (bus.FlushE)              state_d = S_IDLE;
        else if (cnt_q == 7'd63)     state_d = S_FIX;
      end
      S_FIX:  state_d = bus.FlushE ? S_IDLE : S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: stall acts in the issuing cycle, both forced low during reset
  always_comb begin
    bus.StallE = 1'b0;
    bus.DoneE  = 1'b0;
    if (reset) begin
      bus.StallE = (accept && !fast) || (state_q == S_RUN) || (state_q == S_FIX);
      bus.DoneE  = (state_q == S_DONE) && !bus.FlushE;
    end
  end

  assign bus.ResultE = result_q;
  assign bus.RdOut   = rdout_q;

  // Datapath: operand capture, iterations and result registration
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q     <= 7'd0;
      funct_q   <= 3'd0;
      rd_q      <= 5'd0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      mcand_q   <= 64'd0;
      prod_q    <= 128'd0;
      result_q  <= 64'd0;
      rdout_q   <= 5'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            funct_q   <= bus.FunctE;
            rd_q      <= bus.RD_E;
            cnt_q     <= 7'd0;
            neg_res_q <= neg_a ^ neg_b;
            neg_rem_q <= neg_a;
            if (fast) begin
              result_q <= fast_res;
              rdout_q  <= bus.RD_E;
            end else if (is_div_in) begin
              prod_q  <= {64'd0, mag_a};
              mcand_q <= mag_b;
            end else begin
              prod_q  <= {64'd0, mag_b};
              mcand_q <= mag_a;
            end
          end
        end
        S_RUN: begin
          prod_q <= funct_q[2] ? div_step : mul_step;
          cnt_q  <= cnt_q + 7'd1;
        end
        S_FIX: begin
          if (!bus.FlushE) begin
            result_q <= fix_res;
            rdout_q  <= rd_q;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for the iterative multiply/divide sequencer.
module tb_muldiv_seq;
  logic clk = 1'b0;
  logic reset;

  muldiv_seq_if #(.XLEN(64)) bus ();

  muldiv_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  f;
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  rd;
    logic [63:0] exp;
    int          lat;
    int          stl;
  } vec_t;

  vec_t vecs[12];

  int          got_done;
  int          got_stall;
  logic [63:0] got_res;
  logic [4:0]  got_rd;

  // Issue one op, then follow it until DoneE or a cycle budget expires
  task automatic run_op(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b,
                        input logic [4:0] rd);
    @(posedge clk); #1;
    bus.StartE = 1'b1;
    bus.FunctE = f;
    bus.SrcA_E = a;
    bus.SrcB_E = b;
    bus.RD_E   = rd;
    @(negedge clk);
    got_stall = bus.StallE ? 1 : 0;
    got_done  = -1;
    got_res   = 64'hDEAD_BEEF_DEAD_BEEF;
    got_rd    = 5'h1F;
    @(posedge clk); #1;
    bus.StartE = 1'b0;
    for (int k = 1; k < 200 && got_done < 0; k++) begin
      @(negedge clk);
      if (bus.StallE) got_stall++;
      if (bus.DoneE) begin
        got_done = k;
        got_res  = bus.ResultE;
        got_rd   = bus.RdOut;
      end
    end
  endtask

  initial begin
    vecs[0]  = '{3'b000, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5, 64'hFFFF_FFFF_FFFF_FFEB, 66, 66};
    vecs[1]  = '{3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd6, 64'hFFFF_FFFF_FFFF_FFFE, 66, 66};
    vecs[2]  = '{3'b001, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd7, 64'd0, 66, 66};
    vecs[3]  = '{3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd8, 64'hFFFF_FFFF_FFFF_FFFF, 66, 66};
    vecs[4]  = '{3'b100, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 5'd9, 64'hFFFF_FFFF_FFFF_FFFA, 66, 66};
    vecs[5]  = '{3'b110, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 5'd10, 64'hFFFF_FFFF_FFFF_FFFE, 66, 66};
    vecs[6]  = '{3'b101, 64'd20, 64'd3, 5'd11, 64'd6, 66, 66};
    vecs[7]  = '{3'b111, 64'd20, 64'd3, 5'd12, 64'd2, 66, 66};
    vecs[8]  = '{3'b101, 64'd5, 64'd0, 5'd13, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0};
    vecs[9]  = '{3'b100, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd14, 64'h8000_0000_0000_0000, 1, 0};
    vecs[10] = '{3'b110, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd15, 64'd0, 1, 0};
    vecs[11] = '{3'b111, 64'd7, 64'd0, 5'd16, 64'd7, 1, 0};

    reset      = 1'b0;
    bus.StartE = 1'b1;
    bus.FunctE = 3'b000;
    bus.SrcA_E = 64'd1;
    bus.SrcB_E = 64'd1;
    bus.RD_E   = 5'd1;
    bus.FlushE = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_stall", {63'd0, bus.StallE}, 64'd0);
    check_eq("rst_done",  {63'd0, bus.DoneE}, 64'd0);
    check_eq("rst_result", bus.ResultE, 64'd0);
    check_eq("rst_rdout", {59'd0, bus.RdOut}, 64'd0);
    @(posedge clk); #1;
    bus.StartE = 1'b0;
    reset      = 1'b1;

    // StartE with FlushE in IDLE is refused
    @(posedge clk); #1;
    bus.StartE = 1'b1;
    bus.FlushE = 1'b1;
    bus.FunctE = 3'b000;
    @(negedge clk);
    check_eq("flush_start_stall", {63'd0, bus.StallE}, 64'd0);
    @(posedge clk); #1;
    bus.StartE = 1'b0;
    bus.FlushE = 1'b0;
    @(negedge clk);
    check_eq("flush_start_nodone", {63'd0, bus.DoneE | bus.StallE}, 64'd0);

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].rd);
      check_eq($sformatf("v%0d_result", i), got_res, vecs[i].exp);
      check_eq($sformatf("v%0d_rdout", i), {59'd0, got_rd}, {59'd0, vecs[i].rd});
      check_eq($sformatf("v%0d_done_cycle", i), 64'(got_done), 64'(vecs[i].lat));
      check_eq($sformatf("v%0d_stall_cycles", i), 64'(got_stall), 64'(vecs[i].stl));
    end

    // Result and destination hold after the strobe
    @(negedge clk);
    check_eq("hold_result", bus.ResultE, 64'd7);
    check_eq("hold_rdout", {59'd0, bus.RdOut}, 64'd16);
    check_eq("hold_done_low", {63'd0, bus.DoneE}, 64'd0);

    // Flush in RUN cycle 10
    @(posedge clk); #1;
    bus.StartE = 1'b1;
    bus.FunctE = 3'b000;
    bus.SrcA_E = 64'd9;
    bus.SrcB_E = 64'd9;
    bus.RD_E   = 5'd20;
    @(posedge clk); #1;
    bus.StartE = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    bus.FlushE = 1'b1;
    @(negedge clk);
    check_eq("flush_run_stall", {63'd0, bus.StallE}, 64'd1);
    @(posedge clk); #1;
    bus.FlushE = 1'b0;
    got_stall = 0;
    got_done  = 0;
    repeat (80) begin
      @(negedge clk);
      if (bus.StallE) got_stall++;
      if (bus.DoneE)  got_done++;
    end
    check_eq("flush_stall_after", 64'(got_stall), 64'd0);
    check_eq("flush_no_done", 64'(got_done), 64'd0);
    check_eq("flush_result_kept", bus.ResultE, 64'd7);

    run_op(3'b000, 64'd2, 64'd3, 5'd17);
    check_eq("post_flush_mul", got_res, 64'd6);
    check_eq("post_flush_rd", {59'd0, got_rd}, 64'd17);
    check_eq("post_flush_done_cycle", 64'(got_done), 64'd66);

    // Reset in RUN cycle 30
    @(posedge clk); #1;
    bus.StartE = 1'b1;
    bus.FunctE = 3'b100;
    bus.SrcA_E = 64'd100;
    bus.SrcB_E = 64'd7;
    bus.RD_E   = 5'd18;
    @(posedge clk); #1;
    bus.StartE = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_eq("rst_run_stall", {63'd0, bus.StallE}, 64'd0);
    check_eq("rst_run_done",  {63'd0, bus.DoneE}, 64'd0);
    check_eq("rst_run_result_pre", bus.ResultE, 64'd6);
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_run_result", bus.ResultE, 64'd0);
    check_eq("rst_run_rdout", {59'd0, bus.RdOut}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    run_op(3'b101, 64'd20, 64'd3, 5'd19);
    check_eq("post_rst_divu", got_res, 64'd6);
    check_eq("post_rst_rd", {59'd0, got_rd}, 64'd19);
    check_eq("post_rst_done_cycle", 64'(got_done), 64'd66);
    check_eq("post_rst_stall_cycles", 64'(got_stall), 64'd66);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
